// File: rtl/text_term_pkg.sv
// Shared constants, control codes and state encoding for text_term_writer.
// TEXT_TERM_LINE_CLEAR_EN adds the LINE_CLR state (blank each newly entered row).
package text_term_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] BLANK  = 8'h20;
  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE
`ifdef TEXT_TERM_LINE_CLEAR_EN
    , S_LINE_CLR
`endif
  } state_t;

  // row*80 as shift-add; callers truncate to their address width
  function automatic logic [15:0] row_base(input logic [4:0] r);
    logic [15:0] rw;
    rw = {11'd0, r};
    return (rw << 6) + (rw << 4);
  endfunction

endpackage

// File: rtl/text_term_writer.sv
// Byte-stream terminal front end driving an 80x30 text buffer write port.
// Optional TEXT_TERM_LINE_CLEAR_EN: blank every row the cursor advances onto.
module text_term_writer #(
  parameter int         COLS   = text_term_pkg::COLS,
  parameter int         ROWS   = text_term_pkg::ROWS,
  parameter int         ADDR_W = text_term_pkg::ADDR_W,
  parameter logic [7:0] BLANK  = text_term_pkg::BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              write_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        din,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy,
  output logic              overflow
);
  import text_term_pkg::*;

  localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
  localparam logic [7:0]        COLS8   = 8'(COLS);
  localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(COLS * ROWS - 1);
`ifdef TEXT_TERM_LINE_CLEAR_EN
  localparam logic [ADDR_W-1:0] LINE_LAST = ADDR_W'(COLS - 1);
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        din_q, din_d;
  logic              pv_q, pv_d;
  logic [7:0]        pb_q, pb_d;
  logic              ovf_q, ovf_d;

  logic              take;
  logic              adv;
  logic [7:0]        cur;
  logic [4:0]        row_nxt;
  logic [7:0]        tab;
  logic [ADDR_W-1:0] base;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      pv_q    <= 1'b0;
      pb_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      pv_q    <= pv_d;
      pb_q    <= pb_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    pv_d    = pv_q;
    pb_d    = pb_q;
    ovf_d   = ovf_q;
    take    = 1'b0;
    adv     = 1'b0;
    cur     = pv_q ? pb_q : rx_byte;
    row_nxt = (row_q == ROW_MAX) ? '0 : row_q + 5'd1;
    tab     = {1'b0, col_q | 7'd7} + 8'd1;
    base    = ADDR_W'(row_base(row_q));

    unique case (state_q)
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        din_d   = BLANK;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef TEXT_TERM_LINE_CLEAR_EN
      S_LINE_CLR: begin
        we_d    = 1'b1;
        waddr_d = base + cnt_q;
        din_d   = BLANK;
        if (cnt_q == LINE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_IDLE: take = pv_q | rx_dv;
      default: state_d = S_CLEAR;
    endcase

    // pending slot: drained first in IDLE, refilled by a same-cycle strobe
    if (state_q == S_IDLE) begin
      if (pv_q) begin
        pv_d = rx_dv;
        if (rx_dv) pb_d = rx_byte;
      end
    end else if (rx_dv) begin
      if (pv_q) begin
        ovf_d = 1'b1;
      end else begin
        pv_d = 1'b1;
        pb_d = rx_byte;
      end
    end

    if (take) begin
      unique case (1'b1)
        (cur >= 8'h20 && cur <= 8'h7E): begin
          we_d    = 1'b1;
          waddr_d = base + ADDR_W'(col_q);
          din_d   = cur;
          if (col_q == COL_MAX) begin
            col_d = '0;
            adv   = 1'b1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
        (cur == CC_CR): col_d = '0;
        (cur == CC_LF): adv = 1'b1;
        (cur == CC_BS): begin
          if (col_q != '0) begin
            col_d   = col_q - 7'd1;
            we_d    = 1'b1;
            waddr_d = base + ADDR_W'(col_q - 7'd1);
            din_d   = BLANK;
          end
        end
        (cur == CC_TAB): begin
          if (tab >= COLS8) begin
            col_d = '0;
            adv   = 1'b1;
          end else begin
            col_d = tab[6:0];
          end
        end
        (cur == CC_FF): begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end

    if (adv) begin
      row_d = row_nxt;
`ifdef TEXT_TERM_LINE_CLEAR_EN
      state_d = S_LINE_CLR;
      cnt_d   = '0;
`endif
    end
  end

  assign write_en   = we_q;
  assign waddr      = waddr_q;
  assign din        = din_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;

endmodule
